// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - MIPS-style ALU with iterative multiply/divide unit and HI/LO registers
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0]   alu_sum, alu_diff, abs_a, abs_b;
    logic               sign_a, sign_b, is_signed_op;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign sign_a       = a[WIDTH-1];
    assign sign_b       = b[WIDTH-1];
    assign is_signed_op = op[0];
    assign alu_sum      = a + b;
    assign alu_diff     = a - b;
    assign abs_a        = sign_a ? -a : a;
    assign abs_b        = sign_b ? -b : b;

    // Shift-add: {acc_hi, acc_lo} shifts right each step, multiplier bits leave acc_lo as product bits enter.
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
    // Restoring divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_q};

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        m_d       = m_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        result_d  = result_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    dbz_d = 1'b0;
                    case (op)
                        OP_AND: begin
                            result_d = a & b;
                            done_d   = 1'b1;
                        end
                        OP_OR: begin
                            result_d = a | b;
                            done_d   = 1'b1;
                        end
                        OP_ADD: begin
                            result_d = alu_sum;
                            ovf_d    = (sign_a == sign_b) && (alu_sum[WIDTH-1] != sign_a);
                            done_d   = 1'b1;
                        end
                        OP_SUB: begin
                            result_d = alu_diff;
                            ovf_d    = (sign_a != sign_b) && (alu_diff[WIDTH-1] != sign_a);
                            done_d   = 1'b1;
                        end
                        OP_SLT: begin
                            result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                            done_d   = 1'b1;
                        end
                        OP_SLTU: begin
                            result_d = {{(WIDTH-1){1'b0}}, (a < b)};
                            done_d   = 1'b1;
                        end
                        OP_MULTU, OP_MULT: begin
                            m_d       = is_signed_op ? abs_a : a;
                            acc_lo_d  = is_signed_op ? abs_b : b;
                            acc_hi_d  = '0;
                            is_div_d  = 1'b0;
                            neg_d     = is_signed_op && (sign_a ^ sign_b);
                            neg_rem_d = 1'b0;
                            cnt_d     = '0;
                            state_d   = S_BUSY;
                        end
                        OP_DIVU, OP_DIV: begin
                            if (b == '0) begin
                                lo_d     = ALL_ONES;
                                hi_d     = a;
                                result_d = ALL_ONES;
                                dbz_d    = 1'b1;
                                done_d   = 1'b1;
                            end else begin
                                m_d       = is_signed_op ? abs_b : b;
                                acc_lo_d  = is_signed_op ? abs_a : a;
                                acc_hi_d  = '0;
                                is_div_d  = 1'b1;
                                neg_d     = is_signed_op && (sign_a ^ sign_b);
                                neg_rem_d = is_signed_op && sign_a;
                                cnt_d     = '0;
                                state_d   = S_BUSY;
                            end
                        end
                        default: begin
                            result_d = '0;
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_BUSY: begin
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_hi_d = div_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d     = quo_fix;
                    hi_d     = rem_fix;
                    result_d = quo_fix;
                end else begin
                    hi_d     = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d     = prod_fix[WIDTH-1:0];
                    result_d = prod_fix[WIDTH-1:0];
                end
                ovf_d   = 1'b0;
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            m_q       <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            result_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            m_q       <= m_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            dbz_q     <= dbz_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign zero        = (result_q == '0);
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed self-checking bench for alu_mdu
module tb_alu_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         ready, done, zero, overflow, div_by_zero;
    logic [W-1:0] result, hi, lo;

    int tests_run = 0;
    int fails     = 0;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .done(done), .result(result), .hi(hi), .lo(lo),
        .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic accept(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int rdy_hi);
        cyc = 0; rdy_hi = 0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            if (ready) rdy_hi++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({ready, done, zero, overflow, div_by_zero} !== 5'b10100) begin
            fails++; $display("FAIL reset_flags got %b exp 10100", {ready, done, zero, overflow, div_by_zero});
        end
        tests_run++;
        if ({result, hi, lo} !== '0) begin
            fails++; $display("FAIL reset_data got %h %h %h exp 0 0 0", result, hi, lo);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_seq();
        logic [3:0]   ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
        logic [W-1:0] exp [5] = '{32'd4, 32'd14, 32'd18, 32'd6, 32'd0};
        a = 32'd12; b = 32'd6; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op = ops[i];
            @(posedge clk); #1;
            tests_run++;
            if ({done, ready} !== 2'b11 || result !== exp[i]) begin
                fails++; $display("FAIL alu_seq%0d got done=%b ready=%b res=%h exp 1 1 %h", i, done, ready, result, exp[i]);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || hi !== '0 || lo !== '0) begin
            fails++; $display("FAIL alu_done_width got done=%b hi=%h lo=%h exp 0 0 0", done, hi, lo);
        end
        accept(4'b0110, 32'd6, 32'd6);
        tests_run++;
        if (result !== '0 || zero !== 1'b1 || done !== 1'b1) begin
            fails++; $display("FAIL sub_zero got res=%h zero=%b done=%b exp 0 1 1", result, zero, done);
        end
    endtask

    task automatic test_overflow_compare();
        accept(4'b0010, 32'h7FFF_FFFF, 32'd1);
        tests_run++;
        if (result !== 32'h8000_0000 || overflow !== 1'b1 || zero !== 1'b0) begin
            fails++; $display("FAIL add_ovf got res=%h ovf=%b exp 80000000 1", result, overflow);
        end
        accept(4'b0110, 32'h8000_0000, 32'd1);
        tests_run++;
        if (result !== 32'h7FFF_FFFF || overflow !== 1'b1) begin
            fails++; $display("FAIL sub_ovf got res=%h ovf=%b exp 7fffffff 1", result, overflow);
        end
        accept(4'b0111, 32'hFFFF_FFFF, 32'd1);
        tests_run++;
        if (result !== 32'd1 || overflow !== 1'b0) begin
            fails++; $display("FAIL slt got res=%h ovf=%b exp 1 0", result, overflow);
        end
        accept(4'b0101, 32'hFFFF_FFFF, 32'd1);
        tests_run++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            fails++; $display("FAIL sltu got res=%h zero=%b exp 0 1", result, zero);
        end
    endtask

    task automatic test_mul();
        logic [3:0]   ops [3] = '{4'b1001, 4'b1000, 4'b1001};
        logic [W-1:0] av  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [W-1:0] bv  [3] = '{32'd5, 32'd2, 32'hFFFF_FFFF};
        logic [W-1:0] eh  [3] = '{32'hFFFF_FFFF, 32'd1, 32'd0};
        logic [W-1:0] el  [3] = '{32'hFFFF_FFF1, 32'hFFFF_FFFE, 32'h8000_0000};
        int cyc, rdy;
        for (int i = 0; i < 3; i++) begin
            accept(ops[i], av[i], bv[i]);
            wait_done(cyc, rdy);
            tests_run++;
            if (cyc !== 33 || rdy !== 0 || ready !== 1'b1) begin
                fails++; $display("FAIL mul%0d_timing got lat=%0d rdy_busy=%0d ready=%b exp 33 0 1", i, cyc, rdy, ready);
            end
            tests_run++;
            if (hi !== eh[i] || lo !== el[i] || result !== el[i] || overflow !== 1'b0) begin
                fails++; $display("FAIL mul%0d_value got hi=%h lo=%h res=%h exp %h %h %h", i, hi, lo, result, eh[i], el[i], el[i]);
            end
            @(posedge clk); #1;
            tests_run++;
            if (done !== 1'b0) begin
                fails++; $display("FAIL mul%0d_done_width got %b exp 0", i, done);
            end
        end
    endtask

    task automatic test_div();
        logic [3:0]   ops [4] = '{4'b1011, 4'b1010, 4'b1011, 4'b1011};
        logic [W-1:0] av  [4] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7};
        logic [W-1:0] bv  [4] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [W-1:0] eh  [4] = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1};
        logic [W-1:0] el  [4] = '{32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'hFFFF_FFFD};
        int cyc, rdy;
        for (int i = 0; i < 4; i++) begin
            accept(ops[i], av[i], bv[i]);
            wait_done(cyc, rdy);
            tests_run++;
            if (cyc !== 33 || rdy !== 0) begin
                fails++; $display("FAIL div%0d_timing got lat=%0d rdy_busy=%0d exp 33 0", i, cyc, rdy);
            end
            tests_run++;
            if (hi !== eh[i] || lo !== el[i] || result !== el[i] || div_by_zero !== 1'b0) begin
                fails++; $display("FAIL div%0d_value got hi=%h lo=%h dbz=%b exp %h %h 0", i, hi, lo, div_by_zero, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        accept(4'b1010, 32'd9, 32'd0);
        tests_run++;
        if (done !== 1'b1 || ready !== 1'b1 || lo !== 32'hFFFF_FFFF || hi !== 32'd9 ||
            result !== 32'hFFFF_FFFF || div_by_zero !== 1'b1) begin
            fails++; $display("FAIL dbz got done=%b ready=%b hi=%h lo=%h res=%h dbz=%b exp 1 1 9 ffffffff ffffffff 1",
                              done, ready, hi, lo, result, div_by_zero);
        end
        accept(4'b0010, 32'd1, 32'd2);
        tests_run++;
        if (result !== 32'd3 || div_by_zero !== 1'b0 || hi !== 32'd9) begin
            fails++; $display("FAIL dbz_clear got res=%h dbz=%b hi=%h exp 3 0 9", result, div_by_zero, hi);
        end
        accept(4'b0011, 32'd5, 32'd5);
        tests_run++;
        if (result !== '0 || zero !== 1'b1 || done !== 1'b1 || lo !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL nop got res=%h zero=%b done=%b lo=%h exp 0 1 1 ffffffff", result, zero, done, lo);
        end
    endtask

    task automatic test_ignored_start();
        int ndone = 0;
        int when  = 0;
        accept(4'b1001, 32'd6, 32'd7);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin ndone++; when = k; end
            if (k == 10) begin op = 4'b0010; a = 32'd1; b = 32'd1; start = 1'b1; end
            if (k == 11) start = 1'b0;
        end
        tests_run++;
        if (ndone !== 1 || when !== 33) begin
            fails++; $display("FAIL ignored_start got ndone=%0d at=%0d exp 1 33", ndone, when);
        end
        tests_run++;
        if (hi !== '0 || lo !== 32'd42 || result !== 32'd42) begin
            fails++; $display("FAIL ignored_value got hi=%h lo=%h res=%h exp 0 2a 2a", hi, lo, result);
        end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        accept(4'b1011, 32'd100, 32'd7);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ready, done, zero, overflow, div_by_zero} !== 5'b10100 || {result, hi, lo} !== '0) begin
            fails++; $display("FAIL abort_reset got flags=%b res=%h hi=%h lo=%h exp 10100 0 0 0",
                              {ready, done, zero, overflow, div_by_zero}, result, hi, lo);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        tests_run++;
        if (ndone !== 0 || ready !== 1'b1 || lo !== '0) begin
            fails++; $display("FAIL abort_no_done got ndone=%0d ready=%b lo=%h exp 0 1 0", ndone, ready, lo);
        end
    endtask

    initial begin
        test_reset();
        test_alu_seq();
        test_overflow_compare();
        test_mul();
        test_div();
        test_div_by_zero();
        test_ignored_start();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised successor to the single-cycle MIPS ALU. It keeps the AND/OR/ADD/SUB/SLT function codes and adds SLTU, signed-overflow detection and an iterative multiply/divide unit with HI/LO registers. A start/ready/done handshake drives it from the execute stage. All outputs are registered, and the integer datapath stalls on `ready`.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥4)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; accepted only when `ready`=1
- `op`  in  4  function: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 0101 SLTU, 1000 MULTU, 1001 MULT, 1010 DIVU, 1011 DIV; other codes are NOP
- `a`, `b`  in  WIDTH  operands (rs, rt), sampled on accept
- `ready`  out  1  unit can accept a request
- `done`  out  1  one-cycle completion pulse
- `result`  out  WIDTH  ALU result; for mul/div ops, copy of new LO
- `hi`, `lo`  out  WIDTH  mul: high/low product; div: remainder/quotient
- `zero`  out  1  `result`==0
- `overflow`  out  1  signed overflow of last ADD/SUB
- `div_by_zero`  out  1  last DIV/DIVU had `b`=0

## Operation
- Accept happens when `start`=1 and `ready`=1 at a rising edge; operands and op are latched.
- FSM states:
  - IDLE: `ready`=1.
  - BUSY: iterate. `ready`=0. A counter runs 0..WIDTH-1.
  - FIX: sign correction and writeback. `ready`=0.
- ALU ops and NOP stay in IDLE.
  - Results of AND/OR/ADD/SUB/SLT/SLTU are registered.
  - `done` pulses; `hi`/`lo` are unchanged.
  - NOP writes `result`=0.
- ADD/SUB wrap modulo 2^WIDTH.
  - `overflow` = signed overflow of that op.
  - Any other completing op clears `overflow` to 0.
- SLT is a signed compare; SLTU is an unsigned compare. Result is 1 or 0, zero-extended.
- MULT/MULTU: IDLE→BUSY→FIX→IDLE.
  - On accept, latch |a| and |b| (signed op) or a and b (unsigned op).
  - One shift-add step per BUSY cycle.
  - In FIX, negate the 2·WIDTH product if the operand signs differ (signed op only).
  - Write {hi,lo} and pulse `done`.
- DIV/DIVU: restoring division on the same magnitudes, one quotient bit per BUSY cycle.
  - In FIX, negate the quotient if signs differ; the remainder takes the sign of `a`.
  - The quotient truncates toward zero.
  - Signed −2^(WIDTH−1) / −1 gives lo=−2^(WIDTH−1), hi=0, with no flag.
- Divide by zero (`b`=0):
  - No iteration; completes like an ALU op.
  - lo=all ones, hi=`a`, `result`=all ones, `div_by_zero`=1.
- `div_by_zero` is cleared by any other completing op.
- `start` while `ready`=0 is ignored: no queueing and no state change.
- `result`, `hi`, `lo` and the flags hold until the next completion.

## Timing
- Reset values:
  - state IDLE, `ready`=1, `done`=0.
  - `result`=`hi`=`lo`=0, `zero`=1.
  - `overflow`=`div_by_zero`=0.
- Reset is asynchronous and takes effect immediately. It aborts an in-flight mul/div with no `done`.
- Edge 0 is the accepting edge.
- ALU op, NOP and divide-by-zero:
  - Outputs update at edge 0.
  - `done`=1 during the following cycle.
  - `ready` stays 1, so back-to-back accepts on consecutive edges are legal.
- Mul/div:
  - `ready`=0 after edge 0.
  - BUSY spans edges 1..WIDTH; FIX executes at edge WIDTH+1.
  - Outputs update and `done`=1 in the cycle after edge WIDTH+1; `ready`=1 in that same cycle.
  - Latency is WIDTH+1 cycles (33 for WIDTH=32).
  - A new accept is possible on the edge that ends the `done` cycle.
- `done` is exactly one cycle wide per accepted request.
- `zero` is decoded from the `result` register, so it updates on the same edge as `result`.

## Test plan
- Reset, then the original ALU sequence with a=12, b=6:
  - AND → 4; OR → 14; ADD → 18; SUB → 6; SLT → 0.
  - Each op gives one `done` pulse with `ready` held at 1.
  - SUB with a=b=6 → `result`=0, `zero`=1.
- Overflow and compares:
  - ADD 0x7FFFFFFF+1 → 0x80000000, `overflow`=1.
  - SLT a=0xFFFFFFFF, b=1 → 1.
  - SLTU with the same operands → 0.
- MULT a=−3, b=5 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - `ready`=0 throughout BUSY/FIX.
  - MULTU 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100/7 → lo=14, hi=2.
  - DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- DIVU a=9, b=0:
  - `done` one cycle after accept.
  - lo=0xFFFFFFFF, hi=9, `div_by_zero`=1.
  - A following ADD clears the flag.
- MULT started; `start` with ADD pulsed at cycle 10 → ignored, MULT completes with a single `done`.
- `rst_n` low at cycle 15 of a DIV → outputs return to reset values immediately and no `done` follows.
